// File: rtl/mvu_pkg.sv
// Shared width helpers for the MVU datapath (adder tree and fold accumulator).
package mvu_pkg;

    typedef enum logic {
        FOLD_ACCU = 1'b0,
        FOLD_FULL = 1'b1
    } fold_state_e;

    function automatic int sumwidth(input int n_in, input int in_width);
        return in_width + $clog2(n_in);
    endfunction

    function automatic int foldwidth(input int n_fold, input int part_width);
        return part_width + $clog2(n_fold);
    endfunction

    // N_FOLD==1 still needs a 1-bit counter to keep declarations legal.
    function automatic int cntwidth(input int n_fold);
        return (n_fold > 1) ? $clog2(n_fold) : 1;
    endfunction

endpackage

// File: rtl/add_fold_accu.sv
// Fold accumulator: sums N_FOLD consecutive partial sums per PE lane and
// presents the completed dot products on a valid/ready output.
module add_fold_accu
    import mvu_pkg::*;
#(
    parameter int PE          = 2,
    parameter int N_FOLD      = 4,
    parameter int PART_WIDTH  = 16,
    parameter int PART_SIGNED = 1,
    localparam int ACCU_WIDTH = foldwidth(N_FOLD, PART_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ivld,
    output logic                  irdy,
    input  logic [PART_WIDTH-1:0] idat [PE],
    output logic                  ovld,
    input  logic                  ordy,
    output logic [ACCU_WIDTH-1:0] odat [PE]
);

    localparam int               CNT_W    = cntwidth(N_FOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FOLD - 1);

    fold_state_e      state_r;
    fold_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             xfer_in_s;
    logic             xfer_out_s;
    logic             fold_first_s;
    logic             fold_last_s;

    // A pending result only blocks input while the consumer is not taking it.
    assign ovld         = (state_r == FOLD_FULL);
    assign irdy         = (state_r == FOLD_ACCU) || ordy;
    assign xfer_in_s    = ivld && irdy;
    assign xfer_out_s   = ovld && ordy;
    assign fold_first_s = (cnt_r == '0);
    assign fold_last_s  = (cnt_r == CNT_LAST);

    // Next-state: a final beat (re)arms FULL even when the old result leaves this cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FOLD_ACCU: begin
                if (xfer_in_s && fold_last_s) begin
                    state_nxt_s = FOLD_FULL;
                end else begin
                    state_nxt_s = FOLD_ACCU;
                end
            end
            FOLD_FULL: begin
                if (xfer_out_s && !(xfer_in_s && fold_last_s)) begin
                    state_nxt_s = FOLD_ACCU;
                end else begin
                    state_nxt_s = FOLD_FULL;
                end
            end
            default: state_nxt_s = FOLD_ACCU;
        endcase
    end

    // Fold counter advance and wrap.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (xfer_in_s) begin
            if (fold_last_s) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Shared control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FOLD_ACCU;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_lane
        logic [ACCU_WIDTH-1:0] ext_s;
        logic [ACCU_WIDTH-1:0] acc_nxt_s;
        logic [ACCU_WIDTH-1:0] acc_r;

        if (PART_SIGNED != 0) begin : g_sext
            assign ext_s = ACCU_WIDTH'(signed'(idat[p]));
        end else begin : g_zext
            assign ext_s = ACCU_WIDTH'(idat[p]);
        end

        // First beat of a fold overwrites, later beats add (modulo 2^ACCU_WIDTH).
        always_comb begin
            acc_nxt_s = acc_r;
            if (!xfer_in_s) begin
                acc_nxt_s = acc_r;
            end else if (fold_first_s) begin
                acc_nxt_s = ext_s;
            end else begin
                acc_nxt_s = acc_r + ext_s;
            end
        end

        // Lane accumulator register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r <= '0;
            end else begin
                acc_r <= acc_nxt_s;
            end
        end

        assign odat[p] = acc_r;
    end

endmodule
